// File: rtl/matmul_pool_top_if.sv
// Memory-side bus of matmul_pool_top: two synchronous read ports (A, B) and one write port (C).
// The engine drives it through the master modport and the memory block through the slave modport.
interface matmul_pool_top_if #(
   parameter int ADDR_W = 10
);
   logic              mem_read_en_A;
   logic [ADDR_W-1:0] mem_addr_A;
   logic [31:0]       mem_data_A;
   logic              mem_read_en_B;
   logic [ADDR_W-1:0] mem_addr_B;
   logic [31:0]       mem_data_B;
   logic              mem_write_en_C;
   logic [ADDR_W-1:0] mem_addr_C;
   logic [31:0]       mem_data_C;

   modport master (
      output mem_read_en_A, mem_addr_A, input mem_data_A,
      output mem_read_en_B, mem_addr_B, input mem_data_B,
      output mem_write_en_C, mem_addr_C, mem_data_C
   );

   modport slave (
      input mem_read_en_A, mem_addr_A, output mem_data_A,
      input mem_read_en_B, mem_addr_B, output mem_data_B,
      input mem_write_en_C, mem_addr_C, mem_data_C
   );
endinterface

// File: rtl/matmul_pool_top.sv
// 4x4 unsigned 8-bit matrix multiply C = A x B followed by 2x2 average pooling with
// saturation; the four pooled bytes go back to memory as one packed word.
module matmul_pool_top #(
   parameter int                ADDR_W = 10,
   parameter logic [ADDR_W-1:0] BASE_A = 10'h000,
   parameter logic [ADDR_W-1:0] BASE_B = 10'h100,
   parameter logic [ADDR_W-1:0] BASE_C = 10'h200
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               kick_start,
   output logic               ready,
   matmul_pool_top_if.master  mem
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD    = 4'd1,
      COMPUTE = 4'd2,
      POOL    = 4'd3,
      WRITE   = 4'd4
   } state_t;

   state_t      current_state;
   state_t      next_state;
   logic        ready_reg;
   logic        write_back_active;

   logic [2:0]  r_cnt;
   logic [31:0] r_a [4];
   logic [31:0] r_b [4];
   logic [17:0] r_c [4][4];

   logic [2:0]  w_prev;
   logic [17:0] w_row [4];
   logic [19:0] w_qsum [4];
   logic [31:0] w_pool;

   assign ready  = ready_reg;
   assign w_prev = r_cnt - 3'd1;

   always_comb begin
      // NOTE: assign a default before the case so no path leaves next_state unassigned (no latch).
      next_state = IDLE;
      case (current_state)
         IDLE:    next_state = kick_start ? LOAD : IDLE;
         LOAD:    next_state = (r_cnt == 3'd4) ? COMPUTE : LOAD;
         COMPUTE: next_state = (r_cnt == 3'd3) ? POOL : COMPUTE;
         POOL:    next_state = WRITE;
         WRITE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // One row of C per COMPUTE cycle; row index is the cycle counter.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         w_row[j] = '0;
         for (int k = 0; k < 4; k++) begin
            w_row[j] = w_row[j] + ({10'd0, r_a[r_cnt[1:0]][8*k +: 8]} *
                                   {10'd0, r_b[k][8*j +: 8]});
         end
      end
   end

   // Quadrant q = 2*qr + qc, so byte 0 is top-left and byte 3 bottom-right.
   always_comb begin
      w_pool = '0;
      for (int qr = 0; qr < 2; qr++) begin
         for (int qc = 0; qc < 2; qc++) begin
            w_qsum[2*qr+qc] = {2'b00, r_c[2*qr][2*qc]}   + {2'b00, r_c[2*qr][2*qc+1]} +
                              {2'b00, r_c[2*qr+1][2*qc]} + {2'b00, r_c[2*qr+1][2*qc+1]};
            w_pool[8*(2*qr+qc) +: 8] = (w_qsum[2*qr+qc][19:2] > 18'd255) ? 8'hFF
                                                                         : w_qsum[2*qr+qc][9:2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: sequential state uses <= so every flop samples values from before the edge.
         current_state      <= IDLE;
         ready_reg          <= 1'b1;
         write_back_active  <= 1'b0;
         r_cnt              <= '0;
         mem.mem_read_en_A  <= 1'b0;
         mem.mem_read_en_B  <= 1'b0;
         mem.mem_addr_A     <= '0;
         mem.mem_addr_B     <= '0;
         mem.mem_write_en_C <= 1'b0;
         mem.mem_addr_C     <= '0;
         mem.mem_data_C     <= '0;
         // NOTE: the operand/product arrays are small flop banks, not RAM, so they are cleared too.
         for (int i = 0; i < 4; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
            for (int j = 0; j < 4; j++) r_c[i][j] <= '0;
         end
      end else begin
         current_state <= next_state;
         case (current_state)
            IDLE: begin
               r_cnt <= '0;
               if (kick_start) begin
                  ready_reg         <= 1'b0;
                  mem.mem_read_en_A <= 1'b1;
                  mem.mem_read_en_B <= 1'b1;
                  mem.mem_addr_A    <= BASE_A;
                  mem.mem_addr_B    <= BASE_B;
               end
            end
            LOAD: begin
               // Read data lags the strobe by one cycle, hence the row index r_cnt-1.
               if (r_cnt != 3'd0) begin
                  r_a[w_prev[1:0]] <= mem.mem_data_A;
                  r_b[w_prev[1:0]] <= mem.mem_data_B;
               end
               mem.mem_read_en_A <= (r_cnt < 3'd3);
               mem.mem_read_en_B <= (r_cnt < 3'd3);
               if (r_cnt < 3'd3) begin
                  mem.mem_addr_A <= BASE_A + ADDR_W'(r_cnt + 3'd1);
                  mem.mem_addr_B <= BASE_B + ADDR_W'(r_cnt + 3'd1);
               end
               r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
            end
            COMPUTE: begin
               for (int j = 0; j < 4; j++) r_c[r_cnt[1:0]][j] <= w_row[j];
               r_cnt <= r_cnt + 3'd1;
            end
            POOL: begin
               mem.mem_write_en_C <= 1'b1;
               mem.mem_addr_C     <= BASE_C;
               mem.mem_data_C     <= w_pool;
               write_back_active  <= 1'b1;
            end
            WRITE: begin
               mem.mem_write_en_C <= 1'b0;
               write_back_active  <= 1'b0;
               ready_reg          <= 1'b1;
            end
            default: begin
               mem.mem_read_en_A  <= 1'b0;
               mem.mem_read_en_B  <= 1'b0;
               mem.mem_write_en_C <= 1'b0;
               write_back_active  <= 1'b0;
               ready_reg          <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_pool_top.sv
// Bench for matmul_pool_top: behavioural memory, directed and random matrices checked against
// a plain-arithmetic model of multiply, 2x2 floor-average and saturation.
module tb_matmul_pool_top;
   typedef logic [31:0] rows_t [4];

   localparam logic [9:0] BASE_A = 10'h000;
   localparam logic [9:0] BASE_B = 10'h100;
   localparam logic [9:0] BASE_C = 10'h200;

   logic clk        = 1'b0;
   logic rstn       = 1'b0;
   logic kick_start = 1'b0;
   logic ready;

   matmul_pool_top_if #(.ADDR_W(10)) bus ();

   matmul_pool_top dut (
      .clk        (clk),
      .rstn       (rstn),
      .kick_start (kick_start),
      .ready      (ready),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [1024];
   int          cyc            = 0;
   int          n_writes       = 0;
   int          last_write_cyc = 0;
   logic [9:0]  last_waddr     = '0;
   logic [31:0] last_wdata     = '0;
   int          n_checks       = 0;
   int          n_fail         = 0;

   // Memory model: synchronous reads, writes recorded at the edge where write_en is high.
   always @(posedge clk) begin
      if (bus.mem_read_en_A) bus.mem_data_A <= mem[bus.mem_addr_A];
      if (bus.mem_read_en_B) bus.mem_data_B <= mem[bus.mem_addr_B];
      if (bus.mem_write_en_C) begin
         n_writes++;
         last_write_cyc = cyc;
         last_waddr     = bus.mem_addr_C;
         last_wdata     = bus.mem_data_C;
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_pool(input rows_t a, input rows_t b);
      int          c [4][4];
      int          s;
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            c[i][j] = 0;
            for (int k = 0; k < 4; k++)
               c[i][j] += int'(a[i][8*k +: 8]) * int'(b[k][8*j +: 8]);
         end
      for (int qr = 0; qr < 2; qr++)
         for (int qc = 0; qc < 2; qc++) begin
            s = (c[2*qr][2*qc] + c[2*qr][2*qc+1] + c[2*qr+1][2*qc] + c[2*qr+1][2*qc+1]) / 4;
            if (s > 255) s = 255;
            res[8*(2*qr+qc) +: 8] = 8'(s);
         end
      return res;
   endfunction

   function automatic rows_t rand_rows(input int max_val);
      rows_t r;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) r[i][8*j +: 8] = 8'($urandom_range(0, max_val));
      return r;
   endfunction

   // Called at a negedge with ready high; optionally re-kicks during the run.
   task automatic run(input string tag, input rows_t a, input rows_t b,
                      input bit use_golden, input logic [31:0] golden, input int rekick_at);
      int w0, k_cyc, waited;
      for (int r = 0; r < 4; r++) begin
         mem[BASE_A + 10'(r)] = a[r];
         mem[BASE_B + 10'(r)] = b[r];
      end
      w0         = n_writes;
      kick_start = 1'b1;
      k_cyc      = cyc;
      @(negedge clk);
      kick_start = 1'b0;
      check({tag, " ready_drop"}, 32'(ready), 32'd0);
      waited = 0;
      while (!ready && waited < 40) begin
         waited++;
         kick_start = (waited == rekick_at);
         @(negedge clk);
      end
      kick_start = 1'b0;
      check({tag, " ready_back"}, 32'(waited), 32'd11);
      check({tag, " n_writes"}, 32'(n_writes - w0), 32'd1);
      check({tag, " latency"}, 32'(last_write_cyc - k_cyc), 32'd11);
      check({tag, " addr"}, 32'(last_waddr), 32'(BASE_C));
      check({tag, " data"}, last_wdata, ref_pool(a, b));
      if (use_golden) check({tag, " golden"}, last_wdata, golden);
   endtask

   initial begin
      rows_t a, b, a1, a2, b2, ident;
      int    w0, waited;
      a1    = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
      a2    = '{32'h08070605, 32'h04030201, 32'h100F0E0D, 32'h0C0B0A09};
      b2    = '{32'h02010403, 32'h06050807, 32'h0A090C0B, 32'h0E0D100F};
      ident = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};

      repeat (2) @(negedge clk);
      check("reset ready", 32'(ready), 32'd1);
      check("reset state", 32'(dut.current_state), 32'd0);
      check("reset rd_en", {30'd0, bus.mem_read_en_A, bus.mem_read_en_B}, 32'd0);
      check("reset wr_en", 32'(bus.mem_write_en_C), 32'd0);
      check("reset addr", {2'd0, bus.mem_addr_A, bus.mem_addr_B, bus.mem_addr_C}, 32'd0);
      check("reset data_c", bus.mem_data_C, 32'd0);
      rstn = 1'b1;

      run("run1", a1, a1, 1'b1, 32'hFFFFBF9B, 0);
      run("run2", a2, b2, 1'b1, 32'hFFFF9BBF, 0);
      run("zero_a", '{32'd0, 32'd0, 32'd0, 32'd0}, rand_rows(255), 1'b1, 32'h00000000, 0);
      a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      run("all_ff", a, a, 1'b1, 32'hFFFFFFFF, 0);
      run("ident", ident, a1, 1'b1, 32'h0D0B0503, 0);

      for (int it = 0; it < 8; it++) begin
         a = rand_rows((it % 2 == 1) ? 255 : 31);
         b = rand_rows((it % 3 == 0) ? 255 : 31);
         run($sformatf("rand%0d", it), a, b, 1'b0, 32'd0, 0);
      end

      // Kick during LOAD must not start a second run.
      run("rekick", rand_rows(63), rand_rows(63), 1'b0, 32'd0, 2);
      w0 = n_writes;
      repeat (15) @(negedge clk);
      check("rekick extra_writes", 32'(n_writes - w0), 32'd0);
      check("rekick idle", 32'(ready), 32'd1);

      // Reset in the middle of COMPUTE: no write, IDLE immediately.
      a = rand_rows(255);
      b = rand_rows(255);
      for (int r = 0; r < 4; r++) begin
         mem[BASE_A + 10'(r)] = a[r];
         mem[BASE_B + 10'(r)] = b[r];
      end
      w0         = n_writes;
      kick_start = 1'b1;
      @(negedge clk);
      kick_start = 1'b0;
      waited     = 0;
      while (dut.current_state != 4'd2 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check("rst_mid reach_compute", 32'(dut.current_state), 32'd2);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("rst_mid ready", 32'(ready), 32'd1);
      check("rst_mid state", 32'(dut.current_state), 32'd0);
      check("rst_mid strobes", {29'd0, bus.mem_read_en_A, bus.mem_read_en_B, bus.mem_write_en_C}, 32'd0);
      rstn = 1'b1;
      repeat (15) @(negedge clk);
      check("rst_mid no_write", 32'(n_writes - w0), 32'd0);

      run("after_rst", rand_rows(255), rand_rows(15), 1'b0, 32'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
